l1_l2_rr_arbiter: RTL and testbench

- Parametrised N-port round-robin arbiter between the L1 caches (I-cache, D-cache, future ports) and the shared L2 cache / eviction-buffer path.
- Replaces the fixed two-port combinational arbiter with a registered-grant version that has an explicit transaction state machine, fair round-robin rotation, and L2 access/response indications for the pipeline counters.

---
 rtl/l1_l2_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_l1_l2_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_rr_arbiter.sv
// N-port round-robin arbiter between L1 caches and the shared L2 path, with a registered grant.
// Optional per-port performance counters are enabled by L1_L2_ARB_PERF_CNT_EN.
module l1_l2_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        pmem_read,
  input  logic [NUM_PORTS-1:0]        pmem_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] pmem_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] pmem_wdata,
  output logic [NUM_PORTS-1:0]        pmem_resp,
  output logic [LINE_W-1:0]           pmem_rdata,
  output logic                        mem_read_l2,
  output logic                        mem_write_l2,
  output logic [ADDR_W-1:0]           mem_addr_l2,
  output logic [LINE_W-1:0]           mem_wdata_l2,
  input  logic                        mem_resp_l2,
  input  logic [LINE_W-1:0]           mem_rdata_l2,
  output logic                        l2_access,
  output logic                        l2_resp
`ifdef L1_L2_ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]     perf_grant_cnt,
  output logic [NUM_PORTS*32-1:0]     perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     cand;
  logic                 sel_valid;
  logic [NUM_PORTS-1:0] req;
  logic [ADDR_W-1:0]    addr_q, sel_addr;
  logic [LINE_W-1:0]    wdata_q, sel_wdata;
  logic                 op_wr_q, sel_wr;
  logic                 busy;
  logic                 xfer_done;

  assign req       = pmem_read | pmem_write;
  assign busy      = (state == BUSY);
  assign xfer_done = busy && mem_resp_l2;

  // Rotating priority: first requester at or above rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((32'(rr_ptr) + k) % NUM_PORTS);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel       = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (sel == PTR_W'(i)) begin
        sel_addr  = pmem_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = pmem_wdata[i*LINE_W +: LINE_W];
        sel_wr    = pmem_write[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && sel_valid) begin
        grant   <= sel;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        op_wr_q <= sel_wr;
      end
      if (xfer_done) begin
        rr_ptr <= (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state;
    mem_read_l2  = 1'b0;
    mem_write_l2 = 1'b0;
    pmem_resp    = '0;
    case (state)
      IDLE: if (sel_valid) state_d = BUSY;
      BUSY: begin
        mem_read_l2  = !op_wr_q;
        mem_write_l2 = op_wr_q;
        if (mem_resp_l2) state_d = DONE;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          pmem_resp[i] = mem_resp_l2 && (grant == PTR_W'(i));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_l2  = addr_q;
  assign mem_wdata_l2 = wdata_q;
  assign pmem_rdata   = mem_rdata_l2;
  assign l2_access    = mem_read_l2 | mem_write_l2;
  assign l2_resp      = xfer_done;

`ifdef L1_L2_ARB_PERF_CNT_EN
  logic [NUM_PORTS-1:0] waiting;

  // The granted port is only excused from waiting while its transaction is in flight.
  always_comb begin
    waiting = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      waiting[i] = req[i] && !(busy && grant == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (pmem_resp[i] && perf_grant_cnt[i*32 +: 32] != '1)
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
        if (waiting[i] && perf_wait_cnt[i*32 +: 32] != '1)
          perf_wait_cnt[i*32 +: 32] <= perf_wait_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_l2_rr_arbiter.sv
// Self-checking bench for l1_l2_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_l1_l2_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      pmem_read, pmem_write;
  logic [N*AW-1:0]   pmem_addr;
  logic [N*LW-1:0]   pmem_wdata;
  logic [N-1:0]      pmem_resp;
  logic [LW-1:0]     pmem_rdata;
  logic              mem_read_l2, mem_write_l2;
  logic [AW-1:0]     mem_addr_l2;
  logic [LW-1:0]     mem_wdata_l2;
  logic              mem_resp_l2;
  logic [LW-1:0]     mem_rdata_l2;
  logic              l2_access, l2_resp;
`ifdef L1_L2_ARB_PERF_CNT_EN
  logic [N*32-1:0]   perf_grant_cnt, perf_wait_cnt;
`endif

  l1_l2_rr_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .mem_read_l2(mem_read_l2), .mem_write_l2(mem_write_l2),
    .mem_addr_l2(mem_addr_l2), .mem_wdata_l2(mem_wdata_l2),
    .mem_resp_l2(mem_resp_l2), .mem_rdata_l2(mem_rdata_l2),
    .l2_access(l2_access), .l2_resp(l2_resp)
`ifdef L1_L2_ARB_PERF_CNT_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one transaction in flight, a cool-down cycle after each, rotating priority.
  bit            m_active, m_gap, m_write;
  int            m_port, m_ptr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [31:0]   m_gcnt [N];
  logic [31:0]   m_wcnt [N];
  int            obs[$];
  int            rd_cycles;

  task automatic model_reset();
    m_active = 0; m_gap = 0; m_write = 0; m_port = 0; m_ptr = 0;
    m_addr = '0; m_wdata = '0;
    for (int i = 0; i < N; i++) begin m_gcnt[i] = 0; m_wcnt[i] = 0; end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (pmem_read[p] || pmem_write[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    for (int i = 0; i < N; i++) begin
      bit r;
      r = pmem_read[i] || pmem_write[i];
      if (m_active && mem_resp_l2 && i == m_port && m_gcnt[i] != 32'hFFFF_FFFF) m_gcnt[i]++;
      if (r && !(m_active && i == m_port) && m_wcnt[i] != 32'hFFFF_FFFF) m_wcnt[i]++;
    end
    if (m_gap) m_gap = 0;
    else if (m_active) begin
      if (mem_resp_l2) begin
        m_active = 0; m_gap = 1; m_ptr = (m_port + 1) % N;
      end
    end else begin
      w = winner();
      if (w >= 0) begin
        m_active = 1; m_port = w; m_write = pmem_write[w];
        m_addr = pmem_addr[w*AW +: AW]; m_wdata = pmem_wdata[w*LW +: LW];
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    er = '0;
    if (m_active && mem_resp_l2) er[m_port] = 1'b1;
    check_eq("mem_read_l2",  mem_read_l2,  m_active && !m_write);
    check_eq("mem_write_l2", mem_write_l2, m_active && m_write);
    check_eq("l2_access",    l2_access,    m_active);
    check_eq("l2_resp",      l2_resp,      m_active && mem_resp_l2);
    check_eq("pmem_resp",    pmem_resp,    er);
    if (m_active) begin
      check_eq("mem_addr_l2",  mem_addr_l2,  m_addr);
      check_eq("mem_wdata_l2", mem_wdata_l2, m_wdata);
    end
    if (|er) check_eq("pmem_rdata", pmem_rdata, mem_rdata_l2);
`ifdef L1_L2_ARB_PERF_CNT_EN
    for (int i = 0; i < N; i++) begin
      check_eq("perf_grant_cnt", perf_grant_cnt[i*32 +: 32], m_gcnt[i]);
      check_eq("perf_wait_cnt",  perf_wait_cnt[i*32 +: 32],  m_wcnt[i]);
    end
`endif
    if (mem_read_l2) rd_cycles++;
    for (int i = 0; i < N; i++) if (pmem_resp[i]) obs.push_back(i);
  endtask

  // Entered just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    pmem_read = '0; pmem_write = '0; mem_resp_l2 = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 10 && !l2_access; k++) tick();
    if (!l2_access) check_eq("wait_busy_timeout", l2_access, 1'b1);
  endtask

  task automatic serve(input int lat);
    mem_resp_l2 = 1'b0;
    wait_busy();
    for (int k = 0; k < lat - 1; k++) tick();
    mem_resp_l2 = 1'b1;
    tick();
    mem_resp_l2 = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_order(input string tag, input int exp_ord[$]);
    check_eq({tag, "_count"}, obs.size(), exp_ord.size());
    for (int i = 0; i < exp_ord.size(); i++)
      check_eq(tag, (i < obs.size()) ? obs[i] : -1, exp_ord[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    pmem_addr = '0; pmem_wdata = '0; mem_rdata_l2 = '0;
    rd_cycles = 0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    tick();
    check_eq("reset_addr", mem_addr_l2, '0);
    check_eq("reset_wdata", mem_wdata_l2, '0);
    apply_reset();

    // Single read with three-cycle L2 latency, then the pointer has moved past port 0.
    pmem_addr[0*AW +: AW] = 32'h0000_1000;
    pmem_read[0] = 1'b1;
    rd_cycles = 0; obs.delete();
    mem_rdata_l2 = {32{8'hA5}};
    serve(3);
    pmem_read[0] = 1'b0;
    tick();
    check_eq("s1_read_cycles", rd_cycles, 3);
    check_order("s1_order", '{0});
    pmem_read[1:0] = 2'b11;
    obs.delete();
    serve(1);
    pmem_read = '0;
    tick(); tick();
    check_order("s1_ptr_moved", '{1});

    // Two simultaneous requesters from reset.
    apply_reset();
    pmem_read[1:0] = 2'b11;
    obs.delete();
    serve(2);
    pmem_read[0] = 1'b0;
    serve(2);
    pmem_read = '0;
    tick(); tick();
    check_order("s2_order", '{0, 1});

    // All ports continuously requesting, single-cycle L2 latency.
    apply_reset();
    pmem_read = '1;
    obs.delete();
    repeat (5) serve(1);
    pmem_read = '0;
    tick(); tick();
    check_order("s3_order", '{0, 1, 2, 3, 0});
`ifdef L1_L2_ARB_PERF_CNT_EN
    check_eq("s3_grant_p0", perf_grant_cnt[0 +: 32], 32'd2);
    check_eq("s3_grant_p3", perf_grant_cnt[96 +: 32], 32'd1);
`endif

    // Write whose address and data change on the L1 side mid-transaction.
    pmem_addr[1*AW +: AW]  = 32'h0000_2040;
    pmem_wdata[1*LW +: LW] = {8{32'hDEAD_BEEF}};
    pmem_write[1] = 1'b1;
    wait_busy();
    check_eq("s4_write", mem_write_l2, 1'b1);
    pmem_addr[1*AW +: AW]  = 32'h0000_3000;
    pmem_wdata[1*LW +: LW] = rand_line();
    tick(); tick();
    check_eq("s4_addr_hold",  mem_addr_l2,  32'h0000_2040);
    check_eq("s4_wdata_hold", mem_wdata_l2, {8{32'hDEAD_BEEF}});
    mem_resp_l2 = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();

    // Read and write together on one port: write wins.
    pmem_read[0] = 1'b1; pmem_write[0] = 1'b1;
    wait_busy();
    check_eq("s5_write", mem_write_l2, 1'b1);
    check_eq("s5_read",  mem_read_l2,  1'b0);
    mem_resp_l2 = 1'b1;
    tick();
    clear_inputs();
    tick(); tick();

    // Reset asserted mid-transaction, followed by a late L2 response.
    pmem_read[2] = 1'b1;
    wait_busy();
    #2 rst_n = 1'b0;
    #1;
    check_eq("s6_rst_read",   mem_read_l2, 1'b0);
    check_eq("s6_rst_access", l2_access,   1'b0);
    check_eq("s6_rst_addr",   mem_addr_l2, '0);
    check_eq("s6_rst_resp",   pmem_resp,   '0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    mem_resp_l2 = 1'b1;
    #1 check_eq("s6_late_resp", pmem_resp, '0);
    tick();
    mem_resp_l2 = 1'b0;
    pmem_read = 4'b0101;
    obs.delete();
    serve(2);
    clear_inputs();
    tick(); tick();
    check_order("s6_after_reset", '{0});

    // Randomized traffic, including stray L2 responses and mid-request input changes.
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (pmem_read[p] || pmem_write[p]) begin
          if ($urandom_range(7) == 0) begin pmem_read[p] = 1'b0; pmem_write[p] = 1'b0; end
          else if ($urandom_range(15) == 0) pmem_addr[p*AW +: AW] = $urandom;
        end else if ($urandom_range(3) == 0) begin
          int r;
          r = $urandom_range(2);
          pmem_read[p]  = (r != 1);
          pmem_write[p] = (r != 0);
          pmem_addr[p*AW +: AW]  = $urandom;
          pmem_wdata[p*LW +: LW] = rand_line();
        end
      end
      mem_resp_l2  = m_active ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      mem_rdata_l2 = rand_line();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
